// File: rtl/prio_enc_pkg.sv
// Shared types for the iterative priority encoder.
package prio_enc_pkg;

  // Enumeration controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    NONE = 2'd2
  } state_t;

endpackage

// File: rtl/prio_enc_comb.sv
// Purely combinational highest-set-bit encoder.
// idx is the position of the most significant set bit of vec; zero flags an
// all-zero vector (idx is 0 in that case).
module prio_enc_comb #(
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             zero
);

  // Scan upward so the last hit (highest set bit) wins
  always_comb begin
    idx  = '0;
    zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx  = IDX_W'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/prio_enc_iter.sv
// Iterative priority encoder: loads a request vector and emits the indices of
// its set bits, highest first, one per accepted handshake. An all-zero load
// produces a single "none" beat.
// Optional feature: define PRIO_ENC_ITER_COUNT_EN to add out_count, the number
// of bits still pending (including the one currently presented).
module prio_enc_iter
  import prio_enc_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none
`ifdef PRIO_ENC_ITER_COUNT_EN
  ,
  output logic [IDX_W:0]   out_count
`endif
);

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] pend_d;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_zero;
  logic             single;
  logic             load;

  prio_enc_comb #(.WIDTH(WIDTH)) u_enc (
    .vec  (pend),
    .idx  (enc_idx),
    .zero (enc_zero)
  );

  // Exactly one pending bit: clearing the lowest set bit leaves nothing
  assign single = !enc_zero && ((pend & (pend - WIDTH'(1))) == '0);
  assign load   = (state == IDLE) && in_valid && !rst;

  // State and pending-vector registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      state <= state_d;
      pend  <= pend_d;
    end
  end

  // Next-state, pending-bit update and output decode; flush wins over all
  always_comb begin
    state_d   = state;
    pend_d    = pend;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_none  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (load) begin
          if (|in_data) begin
            state_d = SCAN;
            pend_d  = in_data;
          end else begin
            state_d = NONE;
          end
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        out_idx   = enc_idx;
        out_last  = single;
        if (out_ready) begin
          pend_d = pend & ~(WIDTH'(1) << enc_idx);
          if (single) state_d = IDLE;
        end
      end
      NONE: begin
        out_valid = 1'b1;
        out_none  = 1'b1;
        out_last  = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      pend_d  = '0;
    end
  end

`ifdef PRIO_ENC_ITER_COUNT_EN
  logic [IDX_W:0] count;
  logic [IDX_W:0] count_d;

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + (IDX_W+1)'(v[i]);
    return c;
  endfunction

  // Remaining-count register tracks pend: full popcount on load, minus one per accept
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_d;
  end

  // Count update; zero outside SCAN
  always_comb begin
    count_d = count;
    case (state)
      IDLE:    count_d = load ? popcount(in_data) : '0;
      SCAN:    if (out_ready) count_d = count - (IDX_W+1)'(1);
      default: count_d = '0;
    endcase
    if (flush) count_d = '0;
  end

  assign out_count = count;
`else
  logic unused_load;
  assign unused_load = load;
`endif

endmodule

// File: doc/prio_enc_iter.md
PRIO_ENC_ITER -- requirements
Module: prio_enc_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning request vector width; legal values are powers of two from 2 to 256.
REQ-002 SHALL derive IDX_W = $clog2(WIDTH) as a localparam (default 5); it is not overridable.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  load request.
REQ-006 SHALL have port in_data  input  WIDTH  vector to enumerate.
REQ-007 SHALL have port in_ready  output  1  block can accept a load.
REQ-008 SHALL have port flush  input  1  abort the current enumeration.
REQ-009 SHALL have port out_valid  output  1  out_idx is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_idx.
REQ-011 SHALL have port out_idx  output  IDX_W  index of highest set pending bit.
REQ-012 SHALL have port out_last  output  1  current index is the final one.
REQ-013 SHALL have port out_none  output  1  loaded vector was all-zero.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN and NONE.
REQ-015 SHALL drive in_ready=1 only in IDLE with rst low; load occurs when in_valid && in_ready.
REQ-016 SHALL, on a load of a nonzero vector, capture it into pending register pend and enter SCAN; first out_valid appears the next cycle (latency 1).
REQ-017 SHALL, on a load of an all-zero vector, enter NONE; NONE presents out_valid=1, out_none=1, out_idx=0, out_last=1.
REQ-018 SHALL, in SCAN, drive out_valid=1, out_idx = highest set bit of pend, and out_last=1 when exactly one pend bit is set.
REQ-019 SHALL, on out_valid && out_ready in SCAN, clear pend[out_idx]; if out_last, return to IDLE, else stay in SCAN; throughput one index per cycle.
REQ-020 SHALL hold out_idx, out_last and pend stable while out_valid && !out_ready.
REQ-021 SHALL, on out_valid && out_ready in NONE, return to IDLE.
REQ-022 SHALL, on flush in any state, clear pend and enter IDLE the next cycle; flush overrides a simultaneous handshake and a simultaneous load.
REQ-023 SHALL drive out_idx=0, out_last=0 and out_none=0 whenever out_valid=0.
REQ-024 SHALL ignore in_valid outside IDLE; no loads are queued.

Reset
REQ-025 SHALL, with rst high at a clock edge, set state=IDLE, pend=0, out_valid=0, out_idx=0, out_last=0, out_none=0; in_ready=0 while rst is high.
REQ-026 SHALL let reset mid-SCAN discard all pending bits without emitting further indices; rst overrides flush and loads.

Configuration
REQ-027 SHALL, with macro PRIO_ENC_ITER_COUNT_EN defined, add port out_count  output  IDX_W+1  number of pending bits (popcount of pend); it is 0 in IDLE and NONE and equals the full popcount on the first SCAN cycle.
REQ-028 SHALL decrement out_count by one per accepted index; without the macro the port, popcount logic and register are absent and the behaviour is otherwise identical.

Structure
REQ-029 SHALL place the FSM state enum typedef (IDLE/SCAN/NONE) in shared package prio_enc_pkg.
REQ-030 SHALL use one sub-module, prio_enc_comb (parameter WIDTH), a purely combinational highest-set-bit encoder that outputs index plus a zero flag.

Verification (WIDTH=32)
REQ-031 SHALL cover: load 32'h8000_0001 with out_ready=1 at cycle N -> N+1 idx 31 last=0; N+2 idx 0 last=1; N+3 in_ready=1.
REQ-032 SHALL cover: load 32'h0000_0000 -> out_valid=1, out_none=1, idx 0, last=1 for one handshake, then IDLE.
REQ-033 SHALL cover: load 32'h0000_0050 with out_ready low for 3 cycles -> idx 6 held stable 3 cycles, then 6 and 4 (last=1) accepted on consecutive cycles.
REQ-034 SHALL cover: load 32'hFFFF_FFFF; after indices 31..27 are accepted, assert flush together with out_ready -> next cycle out_valid=0, in_ready=1, and 26 is never emitted.
REQ-035 SHALL cover: rst during SCAN of 32'h00F0_0000 with in_valid held high -> all outputs at reset values, no load while rst high, and in_ready=1 the cycle after rst falls.
REQ-036 SHALL cover, with PRIO_ENC_ITER_COUNT_EN: load 32'hF0F0_0000 -> out_count 8 on the first SCAN cycle, 7 after the first accept, and so on down to 1 with last=1, then 0 in IDLE.
